// File: rtl/cla_addsub_if.sv
// cla_addsub_if: operand/result valid-ready bus for cla_addsub_pipe
interface cla_addsub_if #(parameter int WIDTH = 32);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf, zero;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf, zero);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined CLA add/sub, one BLOCK-bit group per stage; CLA_SAT_EN enables saturation on overflow
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input logic        clk,
    input logic        rst,
    cla_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / BLOCK;

    // one lookahead group: returns {carry_out, sum}, carries in sum-of-products form
    function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y, input logic ci);
        logic [BLOCK-1:0] p, g;
        logic [BLOCK:0]   c;
        logic             prop;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & ci);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // level k holds operands with groups 0..k-1 resolved and the carry into group k
    logic [STAGES-1:0] v_q, v_d, c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  sum_q, sum_d, s_fin;
    logic              out_valid_q, out_valid_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic              en;
    logic              a_msb;
    logic [BLOCK:0]    r;

    // advance the whole skewed pipeline unless the output is held by backpressure
    always_comb begin
        en          = !(out_valid_q && !bus.out_ready);
        v_d         = v_q;
        c_d         = c_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        r           = '0;
        s_fin       = '0;
        a_msb       = a_q[STAGES-1][WIDTH-1];
        if (en) begin
            v_d[0] = bus.in_valid;
            a_d[0] = bus.a;
            b_d[0] = bus.sub ? ~bus.b : bus.b;
            c_d[0] = bus.sub ? ~bus.cin : bus.cin;
            s_d[0] = '0;
            for (int k = 0; k < STAGES - 1; k++) begin
                r        = cla_group(a_q[k][k*BLOCK +: BLOCK], b_q[k][k*BLOCK +: BLOCK], c_q[k]);
                v_d[k+1] = v_q[k];
                a_d[k+1] = a_q[k];
                b_d[k+1] = b_q[k];
                c_d[k+1] = r[BLOCK];
                s_d[k+1] = s_q[k];
                s_d[k+1][k*BLOCK +: BLOCK] = r[BLOCK-1:0];
            end
            r     = cla_group(a_q[STAGES-1][WIDTH-1 -: BLOCK], b_q[STAGES-1][WIDTH-1 -: BLOCK], c_q[STAGES-1]);
            s_fin = s_q[STAGES-1];
            s_fin[WIDTH-1 -: BLOCK] = r[BLOCK-1:0];
            ovf_d = (a_msb == b_q[STAGES-1][WIDTH-1]) && (s_fin[WIDTH-1] != a_msb);
`ifdef CLA_SAT_EN
            sum_d = ovf_d ? {a_msb, {(WIDTH-1){~a_msb}}} : s_fin;
`else
            sum_d = s_fin;
`endif
            cout_d      = r[BLOCK];
            zero_d      = (sum_d == '0);
            out_valid_d = v_q[STAGES-1];
        end
    end

    // pipeline and output registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            s_q         <= '{default: '0};
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            c_q         <= c_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed table plus stream, backpressure and reset sequences for cla_addsub_pipe
module tb_cla_addsub_pipe;
    typedef struct packed {
        logic [31:0] s;
        logic        co, ov, z;
    } exp_t;
    typedef struct packed {
        logic [31:0] a, b;
        logic        cin, sub;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    cla_addsub_if #(.WIDTH(32)) bus ();
    cla_addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, n_out = 0;
    exp_t        exp_q[$];
    exp_t        cur_exp, e;
    vec_t        tv[12];
    logic [31:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        logic [31:0] be;
        logic [32:0] r;
        exp_t        x;
        be   = sb ? ~b : b;
        r    = {1'b0, a} + {1'b0, be} + 33'(sb ? !ci : ci);
        x.s  = r[31:0];
        x.co = r[32];
        x.ov = (a[31] == be[31]) && (r[31] != a[31]);
`ifdef CLA_SAT_EN
        if (x.ov) x.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        x.z  = (x.s == 32'h0);
        return x;
    endfunction

    // scoreboard: accepted transactions queue their expectation, results are matched in order
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("sum", bus.sum, e.s);
                chk("cout", 32'(bus.cout), 32'(e.co));
                chk("ovf", 32'(bus.ovf), 32'(e.ov));
                chk("zero", 32'(bus.zero), 32'(e.z));
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb, input exp_t x);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.sub      = sb;
        cur_exp      = x;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb, input exp_t x, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        drive(a, b, ci, sb, x);
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_tv(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                          input logic [31:0] s, input logic co, input logic ov, input logic z);
        tv[i] = {a, b, ci, sb, s, co, ov, z};
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, tot, base, saw;
        logic [31:0] ra, rb;
        logic        rc, rs;
        set_tv(0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        set_tv(1,  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SAT_EN
        set_tv(2,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        set_tv(3,  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        set_tv(4,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        set_tv(2,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        set_tv(3,  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        set_tv(4,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
`endif
        set_tv(5,  32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        set_tv(6,  32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        set_tv(7,  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        set_tv(8,  32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        set_tv(9,  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        set_tv(10, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        set_tv(11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", bus.sum, 32'd0);
        chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // latency: accepted at edge N, visible after edge N+4
        drive(tv[0].a, tv[0].b, tv[0].cin, tv[0].sub, tv[0].e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency_valid_%0d", i), 32'(bus.out_valid), 32'(i == 4));
        end
        @(posedge clk);
        #1;
        drain();

        // directed table, back to back
        for (int i = 0; i < 12; i++) send(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, tv[i].e, w);
        bus.in_valid = 1'b0;
        drain();

        // random stream: one accept per cycle, all results in order
        tot  = 0;
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            ra = (i % 10 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (i % 10 == 5) ? 32'h8000_0000 : $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
            tot += w;
        end
        bus.in_valid = 1'b0;
        chk("stream_stalls", 32'(tot), 32'd0);
        drain();
        chk("stream_count", 32'(n_out - base), 32'd100);

        // backpressure for 6 cycles mid-stream
        base = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                held = bus.sum;
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("bp_sum_stable", bus.sum, held);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(n_out - base), 32'd20);

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) send(tv[11].a, tv[11].b, 1'b0, 1'b0, tv[11].e, w);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", bus.sum, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) saw++;
        end
        chk("stale_results", 32'(saw), 32'd0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
